frame_buf_index_ctrl: RTL and testbench

- Parametrised N-buffer frame index controller, successor to the fixed 4-slot HDMI write-request generator.
- Detects input frame start on vsync and issues a write request/ack handshake to the frame-write DMA.
- Rotates the write buffer index while never targeting the buffer being read or the newest completed frame.
- Publishes the newest completed frame to the read side on each read frame start; counts dropped or overrun frames.

---
 rtl/frame_buf_index_ctrl.sv | 159 +++++++++++++++
 tb/tb_frame_buf_index_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_index_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_buf_index_ctrl: N-buffer write/read index rotation for frame DMA.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module frame_buf_index_ctrl #(
  parameter int unsigned BUF_NUM = 3,
  parameter int unsigned IDX_W   = 2,
  parameter bit          VS_POL  = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             hdmi_vsync,
  output logic             write_req,
  input  logic             write_req_ack,
  input  logic             write_done,
  output logic [IDX_W-1:0] write_addr_index,
  input  logic             rd_frame_start,
  output logic [IDX_W-1:0] read_addr_index,
  output logic             read_valid,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic c_VS_INACT = ~VS_POL;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WRITING = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_vs_d0, r_vs_d1;
  logic             r_write_req, w_req_nxt;
  logic [IDX_W-1:0] r_wr_idx, w_wr_idx_nxt;
  logic [IDX_W-1:0] r_rd_idx;
  logic [IDX_W-1:0] r_last_done;
  logic             r_done_valid;
  logic             r_read_valid;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_vs_edge;
  logic             w_publish;
  logic             w_drop;
  logic [IDX_W-1:0] w_excl_last;
  logic [IDX_W-1:0] w_cand [3];
  logic [IDX_W-1:0] w_sel;

  function automatic logic [IDX_W-1:0] f_cand(input logic [IDX_W-1:0] base,
                                              input logic [31:0] step);
    logic [31:0] v;
    v = 32'(base) + step;
    if (v >= BUF_NUM) v = v - BUF_NUM;
    return v[IDX_W-1:0];
  endfunction

  assign w_vs_edge = (r_vs_d0 == VS_POL) && (r_vs_d1 != VS_POL);

  // A frame finishing this cycle is already the newest one for selection.
  assign w_excl_last = (r_state == ST_WRITING && write_done) ? r_wr_idx : r_last_done;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_cand[k] = f_cand(r_wr_idx, 32'(k + 1));
    end
    if (w_cand[0] != r_rd_idx && w_cand[0] != w_excl_last)
      w_sel = w_cand[0];
    else if (w_cand[1] != r_rd_idx && w_cand[1] != w_excl_last)
      w_sel = w_cand[1];
    else
      w_sel = w_cand[2];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_write_req;
    w_wr_idx_nxt = r_wr_idx;
    w_publish    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_edge) begin
          w_wr_idx_nxt = w_sel;
          w_req_nxt    = 1'b1;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        w_drop = w_vs_edge;
        if (write_req_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_WRITING;
        end
      end
      ST_WRITING: begin
        if (write_done) begin
          w_publish = 1'b1;
          if (w_vs_edge) begin
            w_wr_idx_nxt = w_sel;
            w_req_nxt    = 1'b1;
            w_state_nxt  = ST_REQ;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_vs_edge) begin
          w_drop      = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_vs_d0      <= c_VS_INACT;
      r_vs_d1      <= c_VS_INACT;
      r_write_req  <= 1'b0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_last_done  <= '0;
      r_done_valid <= 1'b0;
      r_read_valid <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_vs_d0     <= hdmi_vsync;
      r_vs_d1     <= r_vs_d0;
      r_state     <= w_state_nxt;
      r_write_req <= w_req_nxt;
      r_wr_idx    <= w_wr_idx_nxt;
      if (w_publish) begin
        r_last_done  <= r_wr_idx;
        r_done_valid <= 1'b1;
      end
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}}))
        r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (rd_frame_start) begin
        if (w_publish) begin
          r_rd_idx     <= r_wr_idx;
          r_read_valid <= 1'b1;
        end else if (r_done_valid) begin
          r_rd_idx     <= r_last_done;
          r_read_valid <= 1'b1;
        end
      end
    end
  end

  assign write_req        = r_write_req;
  assign write_addr_index = r_wr_idx;
  assign read_addr_index  = r_rd_idx;
  assign read_valid       = r_read_valid;
  assign drop_cnt         = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_index_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_buf_index_ctrl: two instances (3 buf/active-high, 4 buf/low).     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_frame_buf_index_ctrl;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic vs   = 1'b0;
  logic ack  = 1'b0;
  logic done = 1'b0;
  logic rds  = 1'b0;
  logic vs_n;

  logic       req0, rv0;
  logic [1:0] wi0, ri0, dc0;
  logic       req1, rv1;
  logic [1:0] wi1, ri1;
  logic [7:0] dc1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;
  assign vs_n = ~vs;

  frame_buf_index_ctrl #(.BUF_NUM(3), .IDX_W(2), .VS_POL(1'b1), .CNT_W(2)) u_dut0 (
    .pclk(pclk), .rst(rst), .hdmi_vsync(vs),
    .write_req(req0), .write_req_ack(ack), .write_done(done),
    .write_addr_index(wi0), .rd_frame_start(rds),
    .read_addr_index(ri0), .read_valid(rv0), .drop_cnt(dc0)
  );

  frame_buf_index_ctrl #(.BUF_NUM(4), .IDX_W(2), .VS_POL(1'b0), .CNT_W(8)) u_dut1 (
    .pclk(pclk), .rst(rst), .hdmi_vsync(vs_n),
    .write_req(req1), .write_req_ack(ack), .write_done(done),
    .write_addr_index(wi1), .rd_frame_start(rds),
    .read_addr_index(ri1), .read_valid(rv1), .drop_cnt(dc1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 requesting, 2 writing; 'vsync active' is the logical vs.
  int m_ph[2], m_wi[2], m_ri[2], m_last[2], m_drop[2];
  bit m_req[2], m_rv[2], m_dv[2];
  bit h_new, h_old, armed;
  int bufs[2]   = '{3, 4};
  int cmax[2]   = '{3, 255};

  function automatic int next_buf(int b, int wi, int rd, int last);
    for (int k = 1; k <= 3; k++) begin
      if (((wi + k) % b) != rd && ((wi + k) % b) != last) return (wi + k) % b;
    end
    return -1;
  endfunction

  always @(posedge pclk) begin
    bit e, pub;
    int owi, olast, ori;
    bit odv;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_ph[d] = 0; m_wi[d] = 0; m_ri[d] = 0; m_last[d] = 0; m_drop[d] = 0;
        m_req[d] = 0; m_rv[d] = 0; m_dv[d] = 0;
      end
      h_new = 0; h_old = 0; armed = 1;
    end else begin
      e = h_new && !h_old;
      for (int d = 0; d < 2; d++) begin
        owi = m_wi[d]; olast = m_last[d]; ori = m_ri[d]; odv = m_dv[d];
        pub = 0;
        if (m_ph[d] == 0) begin
          if (e) begin m_wi[d] = next_buf(bufs[d], owi, ori, olast); m_req[d] = 1; m_ph[d] = 1; end
        end else if (m_ph[d] == 1) begin
          if (e && m_drop[d] < cmax[d]) m_drop[d]++;
          if (ack) begin m_req[d] = 0; m_ph[d] = 2; end
        end else begin
          if (done) begin
            pub = 1; m_last[d] = owi; m_dv[d] = 1;
            if (e) begin m_wi[d] = next_buf(bufs[d], owi, ori, owi); m_req[d] = 1; m_ph[d] = 1; end
            else m_ph[d] = 0;
          end else if (e) begin
            if (m_drop[d] < cmax[d]) m_drop[d]++;
            m_req[d] = 1; m_ph[d] = 1;
          end
        end
        if (rds) begin
          if (pub) begin m_ri[d] = owi; m_rv[d] = 1; end
          else if (odv) begin m_ri[d] = olast; m_rv[d] = 1; end
        end
      end
      h_old = h_new; h_new = vs;
    end
    #1;
    if (armed) begin
      chk("req0", 32'(req0), 32'(m_req[0]));   chk("req1", 32'(req1), 32'(m_req[1]));
      chk("wi0", 32'(wi0), m_wi[0]);           chk("wi1", 32'(wi1), m_wi[1]);
      chk("ri0", 32'(ri0), m_ri[0]);           chk("ri1", 32'(ri1), m_ri[1]);
      chk("rv0", 32'(rv0), 32'(m_rv[0]));      chk("rv1", 32'(rv1), 32'(m_rv[1]));
      chk("dc0", 32'(dc0), m_drop[0]);         chk("dc1", 32'(dc1), m_drop[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask
  task automatic vs_pulse();
    vs = 1; cyc(2); vs = 0; cyc(2);
  endtask
  task automatic pulse_ack();
    ack = 1; cyc(1); ack = 0; cyc(1);
  endtask
  task automatic pulse_done();
    done = 1; cyc(1); done = 0; cyc(1);
  endtask
  task automatic pulse_rds();
    rds = 1; cyc(1); rds = 0; cyc(1);
  endtask

  initial begin
    cyc(3);
    chk("rst_req", 32'(req0), 0); chk("rst_wi", 32'(wi0), 0); chk("rst_dc", 32'(dc0), 0);
    rst = 0;
    cyc(1);
    // First frame: request timing and ack release
    vs = 1; cyc(1);
    chk("req_early", 32'(req0), 0);
    cyc(1);
    chk("req_2nd_edge", 32'(req0), 1); chk("first_wi0", 32'(wi0), 1); chk("first_wi1", 32'(wi1), 1);
    vs = 0; cyc(2);
    ack = 1; cyc(1); ack = 0;
    chk("req_after_ack", 32'(req0), 0);
    cyc(1);
    pulse_done();
    pulse_rds();
    chk("rd_idx1", 32'(ri0), 1); chk("rd_valid", 32'(rv0), 1);
    // Frames 2..4: rotation, skips and wraps
    vs_pulse(); chk("f2_wi0", 32'(wi0), 2); chk("f2_wi1", 32'(wi1), 2);
    pulse_ack(); pulse_done();
    vs_pulse(); chk("f3_wrap_wi0", 32'(wi0), 0); chk("f3_wi1", 32'(wi1), 3);
    pulse_ack(); pulse_done(); pulse_rds();
    chk("f3_ri1", 32'(ri1), 3);
    vs_pulse(); chk("f4_wi0", 32'(wi0), 1); chk("f4_wrap_wi1", 32'(wi1), 0);
    pulse_ack();
    // Overrun while writing
    vs_pulse();
    chk("ovr_dc0", 32'(dc0), 1); chk("ovr_req", 32'(req0), 1);
    chk("ovr_same_wi0", 32'(wi0), 1); chk("ovr_ri0", 32'(ri0), 0);
    pulse_ack();
    // write_done and rd_frame_start together: bypass
    done = 1; rds = 1; cyc(1); done = 0; rds = 0;
    chk("bypass_ri0", 32'(ri0), 1); chk("bypass_ri1", 32'(ri1), 0);
    cyc(1);
    // write_done coinciding with vs edge
    vs_pulse(); pulse_ack();
    vs = 1; cyc(1); done = 1; cyc(1); done = 0; vs = 0;
    chk("dv_req", 32'(req0), 1); chk("dv_wi0", 32'(wi0), 0); chk("dv_wi1", 32'(wi1), 2);
    cyc(1);
    pulse_rds();
    chk("dv_ri0", 32'(ri0), 2); chk("dv_ri1", 32'(ri1), 1);
    // Drops while requesting, saturation of the 2-bit counter
    vs_pulse(); vs_pulse(); vs_pulse();
    chk("sat_dc0", 32'(dc0), 3); chk("dc1_4", 32'(dc1), 4);
    vs = 1; cyc(1); ack = 1; cyc(1); ack = 0; vs = 0;
    chk("ackwin_req", 32'(req0), 0); chk("ackwin_dc1", 32'(dc1), 5); chk("ackwin_dc0", 32'(dc0), 3);
    cyc(2);
    pulse_done();
    // Reset in the middle of a request
    vs_pulse(); chk("pre_rst_req", 32'(req0), 1);
    rst = 1; cyc(1);
    chk("mid_rst_req", 32'(req0), 0); chk("mid_rst_wi", 32'(wi1), 0);
    chk("mid_rst_ri", 32'(ri0), 0); chk("mid_rst_dc", 32'(dc1), 0);
    rst = 0; cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
